// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // A prescaler of 1 still needs a 1-bit register to stay legal.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle STEP on the last one.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic STEP
);

  localparam int PW = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign STEP = EN && (pcnt == LAST);

  always_ff @(posedge Clk) begin
    if (RST || CLR) begin
      pcnt <= '0;
    end else if (STEP) begin
      pcnt <= '0;
    end else if (EN) begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with load clamp, prescaled enable, wrap/saturate
// bounds, a registered terminal-count pulse and a combinational zero flag.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             ZERO
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  // No handshake: LOAD and EN are level-sampled at every rising edge,
  // with priority RST > LOAD > step > hold.
  logic             step;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_out;
  logic             next_tc;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .Clk (Clk),
    .RST (RST),
    .CLR (LOAD),
    .EN  (EN),
    .STEP(step)
  );

  assign load_val = (DIN > MAX) ? MAX : DIN;

  // Bounds are checked before the +/-1 so the arithmetic never leaves WIDTH bits.
  always_comb begin
    next_out = OUT;
    next_tc  = 1'b0;
    if (LOAD) begin
      next_out = load_val;
    end else if (step) begin
      if (UP == DIR_UP) begin
        if (OUT < MAX) begin
          next_out = OUT + WIDTH'(1);
        end else begin
          next_tc = 1'b1;
          if (SATURATE == MODE_WRAP) next_out = '0;
        end
      end else begin
        if (OUT != '0) begin
          next_out = OUT - WIDTH'(1);
        end else begin
          next_tc = 1'b1;
          if (SATURATE == MODE_WRAP) next_out = MAX;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      OUT <= '0;
      TC  <= 1'b0;
    end else begin
      OUT <= next_out;
      TC  <= next_tc;
    end
  end

  assign ZERO = (OUT == '0);

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised up/down counter, successor to the fixed 4-bit down counter. It adds:
- generic width and modulus,
- runtime direction select,
- parallel load,
- count enable with a built-in prescaler,
- wrap or saturate mode,
- terminal-count and zero flags.

It is the general timing/sequencing counter for board-level designs in this codebase, driven by the single system clock.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥1)
- MAX_VAL, 2**WIDTH-1, upper count bound; must be < 2**WIDTH
- PRESCALE, 1, enabled cycles per count step (≥1)
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
- Clk  in  1  system clock, rising-edge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  count enable; advances the prescaler
- UP  in  1  direction: 1 = count up, 0 = count down
- LOAD  in  1  parallel load strobe
- DIN  in  WIDTH  load value
- OUT  out  WIDTH  registered count
- TC  out  1  registered terminal-count pulse
- ZERO  out  1  combinational, high when OUT == 0

## Operation
- Internal prescaler register pcnt:
  - range 0..PRESCALE-1; width max(1, $clog2(PRESCALE)).
  - A step strobe is generated when EN=1 and pcnt == PRESCALE-1; pcnt then returns to 0.
  - EN=1 without a step: pcnt increments.
  - EN=0: pcnt holds.
  - PRESCALE=1: every EN cycle is a step.
- Priority per edge: RST > LOAD > step > hold.
  - RST: OUT=0, pcnt=0, TC=0.
  - LOAD: OUT = min(DIN, MAX_VAL), pcnt=0, TC=0. EN and UP are ignored that cycle.
  - Step with UP=1:
    - OUT < MAX_VAL: OUT+1.
    - OUT == MAX_VAL, wrap mode: OUT=0, TC=1.
    - OUT == MAX_VAL, saturate mode: OUT holds, TC=1.
  - Step with UP=0:
    - OUT > 0: OUT-1.
    - OUT == 0, wrap mode: OUT=MAX_VAL, TC=1.
    - OUT == 0, saturate mode: OUT holds, TC=1.
  - No step: OUT holds, TC=0.
- TC is high for exactly one cycle per boundary step. Back-to-back boundary steps give TC high on consecutive cycles.
- Changing UP mid-prescale window does not disturb pcnt. Direction is sampled only on the step cycle.
- Reset values: OUT=0, TC=0, ZERO=1, pcnt=0.
- Arithmetic is unsigned, WIDTH bits. No intermediate result exceeds WIDTH bits; bounds are compared before increment/decrement.

## Timing
- One-cycle latency: a step or load qualified in cycle n appears on OUT after the rising edge ending cycle n. TC updates on the same edge as OUT.
- ZERO follows OUT combinationally, with no extra latency.
- RST asserted mid-count or mid-prescale takes effect at the next edge regardless of LOAD/EN.
- No handshake. LOAD and EN are level-sampled at each edge.

## Structure
- Package counter_pkg:
  - DIR_DOWN=1'b0, DIR_UP=1'b1
  - MODE_WRAP=0, MODE_SAT=1
  - function clog2_min1 for the prescaler width
- Sub-module tick_prescaler (params PRESCALE; ports Clk, RST, CLR, EN, STEP): owns pcnt and emits a one-cycle STEP. CLR is driven by LOAD.
- Top level holds the OUT/TC registers, the bound logic, the load clamp and ZERO.

## Test plan
- Reset (WIDTH=4): hold RST 2 cycles with EN=1, LOAD=1 → OUT=0, TC=0, ZERO=1 after the first edge.
- Down-wrap (PRESCALE=1, SATURATE=0): LOAD DIN=2, then EN=1, UP=0 → OUT 2,1,0,15,14. TC=1 only in the cycle OUT=15; ZERO=1 only in the cycle OUT=0.
- Saturate up (MAX_VAL=9, SATURATE=1): LOAD 8, then EN=1, UP=1 for 3 cycles → OUT 9,9,9; TC 0,1,1.
- Prescaler (PRESCALE=3): from OUT=0, EN=1, UP=1 → OUT steps on cycles 3,6. Dropping EN for 2 cycles after cycle 7 delays the next step to cycle 11.
- Load clamp/priority (MAX_VAL=9): LOAD=1, DIN=12, EN=1 in the same cycle with pcnt=2 (PRESCALE=3) → OUT=9, TC=0, pcnt=0. The next step occurs 3 EN cycles later.
- Reset mid-operation: while counting with UP=1 at OUT=5 and LOAD=1, DIN=7, assert RST → OUT=0, TC=0. Counting resumes from 0 after release.
